// File: rtl/async_pkg.sv
// Shared definitions for the async req/ack channel blocks: arbiter state encoding
// and a width helper for counters and pointers.
package async_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_POLL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Ceiling log2, never less than 1 so single-value counters still get a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/async_rr_arbiter.sv
// Round-robin arbiter merging num_src req/ack sources onto one destination channel.
// Sources are polled one at a time with a bounded wait; each word is tagged with its source index.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// ST_START | first cycle after reset: raise src_req for the source at ptr
// ST_POLL  | src_req held on source ptr, waiting up to wait_cycles for its ack
// ST_DRAIN | src_req dropped; catch an ack that crossed the falling request
// ST_HOLD  | one word buffered, waiting for dst_req before polling resumes
module async_rr_arbiter
    import async_pkg::*;
#(
    parameter int data_width  = 32,
    parameter int num_src     = 4,
    parameter int id_width    = 2,
    parameter int wait_cycles = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [num_src-1:0]             src_req,
    input  logic [num_src-1:0]             src_ack,
    input  logic [data_width*num_src-1:0]  src_din,
    input  logic                           dst_req,
    output logic                           dst_ack,
    output logic [data_width-1:0]          dst_dout,
    output logic [id_width-1:0]            dst_id,
    output logic                           err
);

    localparam int PTR_W = clog2(num_src);
    localparam int CNT_W = clog2(wait_cycles);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(num_src - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(wait_cycles - 1);

    state_t                  state, state_n;
    logic [PTR_W-1:0]        ptr, ptr_n, ptr_inc;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [data_width-1:0]   data_r, data_n;
    logic [PTR_W-1:0]        id_r, id_n;
    logic [num_src-1:0]      src_req_n;
    logic                    dst_ack_n;
    logic [data_width-1:0]   dst_dout_n;
    logic [id_width-1:0]     dst_id_n;
    logic                    err_n;

    logic [data_width-1:0]   din_slice [num_src];
    logic [data_width-1:0]   din_sel;
    logic [num_src-1:0]      ptr_dec, ptr_inc_dec, legit_mask;
    logic                    ack_hit, stray_ack;

    assign ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);

    for (genvar i = 0; i < num_src; i++) begin : g_src
        assign din_slice[i]   = src_din[data_width*i +: data_width];
        assign ptr_dec[i]     = (ptr == PTR_W'(i));
        assign ptr_inc_dec[i] = (ptr_inc == PTR_W'(i));
    end

    assign din_sel = din_slice[ptr];

    // Only the polled source may ack, and only while polling or draining.
    assign legit_mask = ((state == ST_POLL) || (state == ST_DRAIN)) ? ptr_dec : '0;
    assign ack_hit    = |(src_ack & legit_mask);
    assign stray_ack  = |(src_ack & ~legit_mask);

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        cnt_n      = cnt;
        data_n     = data_r;
        id_n       = id_r;
        src_req_n  = src_req;
        dst_ack_n  = 1'b0;
        dst_dout_n = dst_dout;
        dst_id_n   = dst_id;
        err_n      = err | stray_ack;

        case (state)
            ST_START: begin
                src_req_n = ptr_dec;
                cnt_n     = '0;
                state_n   = ST_POLL;
            end
            ST_POLL: begin
                if (ack_hit) begin
                    data_n    = din_sel;
                    id_n      = ptr;
                    src_req_n = '0;
                    state_n   = ST_HOLD;
                end else if (cnt == CNT_LAST) begin
                    src_req_n = '0;
                    state_n   = ST_DRAIN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (ack_hit) begin
                    data_n  = din_sel;
                    id_n    = ptr;
                    state_n = ST_HOLD;
                end else begin
                    ptr_n     = ptr_inc;
                    src_req_n = ptr_inc_dec;
                    cnt_n     = '0;
                    state_n   = ST_POLL;
                end
            end
            ST_HOLD: begin
                // ptr still equals id_r here, so ptr_inc resumes after the served source.
                if (dst_req) begin
                    dst_ack_n  = 1'b1;
                    dst_dout_n = data_r;
                    dst_id_n   = id_width'(id_r);
                    ptr_n      = ptr_inc;
                    src_req_n  = ptr_inc_dec;
                    cnt_n      = '0;
                    state_n    = ST_POLL;
                end
            end
            default: begin
                state_n = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_START;
            ptr      <= '0;
            cnt      <= '0;
            data_r   <= '0;
            id_r     <= '0;
            src_req  <= '0;
            dst_ack  <= 1'b0;
            dst_dout <= '0;
            dst_id   <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            data_r   <= data_n;
            id_r     <= id_n;
            src_req  <= src_req_n;
            dst_ack  <= dst_ack_n;
            dst_dout <= dst_dout_n;
            dst_id   <= dst_id_n;
            err      <= err_n;
        end
    end

endmodule

// File: tb/tb_async_rr_arbiter.sv
// Self-checking bench for async_rr_arbiter: directed timing scenarios plus a randomized
// run checked against a word-queue scoreboard and the round-robin resume rule.
module tb_async_rr_arbiter;

    localparam int DW = 32;
    localparam int NS = 4;
    localparam int IW = 2;
    localparam int WC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NS-1:0]    src_req;
    logic [NS-1:0]    src_ack;
    logic [NS-1:0]    ack_auto = '0;
    logic [NS-1:0]    ack_inj  = '0;
    logic [NS-1:0]    auto_en  = '0;
    logic [NS-1:0]    req_seen = '0;
    logic [DW*NS-1:0] src_din;
    logic [DW-1:0]    din_v [NS];
    logic             dst_req = 1'b0;
    logic             dst_ack;
    logic [DW-1:0]    dst_dout;
    logic [IW-1:0]    dst_id;
    logic             err;
    bit               rand_mode = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          id;
        logic [31:0] d;
    } exp_t;
    exp_t exp_q [$];

    assign src_ack = ack_auto | ack_inj;
    assign src_din = {din_v[3], din_v[2], din_v[1], din_v[0]};

    async_rr_arbiter #(
        .data_width (DW),
        .num_src    (NS),
        .id_width   (IW),
        .wait_cycles(WC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src_req  (src_req),
        .src_ack  (src_ack),
        .src_din  (src_din),
        .dst_req  (dst_req),
        .dst_ack  (dst_ack),
        .dst_dout (dst_dout),
        .dst_id   (dst_id),
        .err      (err)
    );

    // Source model: registers an ack one cycle after it sees its request, once per request.
    always @(negedge clk) req_seen = src_req;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NS; i++) begin
            ack_auto[i] = (auto_en[i] === 1'b1 && req_seen[i] === 1'b1 && ack_auto[i] === 1'b0 &&
                           (!rand_mode || $urandom_range(0, 3) != 0)) ? 1'b1 : 1'b0;
            if (rand_mode) din_v[i] = $urandom;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        ack_inj   = '0;
        rand_mode = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (src_req !== '0)  begin n_fail++; $display("FAIL rst_src_req: got %b want 0", src_req); end
        n_tests++;
        if (dst_ack !== 1'b0) begin n_fail++; $display("FAIL rst_dst_ack: got %b want 0", dst_ack); end
        n_tests++;
        if (dst_dout !== '0) begin n_fail++; $display("FAIL rst_dst_dout: got %h want 0", dst_dout); end
        n_tests++;
        if (dst_id !== '0)   begin n_fail++; $display("FAIL rst_dst_id: got %0d want 0", dst_id); end
        n_tests++;
        if (err !== 1'b0)    begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
        rst = 1'b0;
    endtask

    task automatic test_first_word();
        int k_ack;
        logic [DW-1:0] got_d;
        logic [IW-1:0] got_id;
        k_ack  = -1;
        got_d  = 'x;
        got_id = 'x;
        for (int i = 0; i < NS; i++) din_v[i] = '0;
        din_v[0] = 32'd7;
        auto_en  = 4'b0001;
        dst_req  = 1'b1;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (dst_ack === 1'b1 && k_ack < 0) begin
                k_ack  = k;
                got_d  = dst_dout;
                got_id = dst_id;
            end
        end
        n_tests++;
        if (k_ack !== 4) begin n_fail++; $display("FAIL t1_ack_cycle: got %0d want 4", k_ack); end
        n_tests++;
        if (got_d !== 32'd7) begin n_fail++; $display("FAIL t1_dout: got %0d want 7", got_d); end
        n_tests++;
        if (got_id !== 2'd0) begin n_fail++; $display("FAIL t1_id: got %0d want 0", got_id); end
    endtask

    task automatic test_skip_idle();
        int k_ack, n0, n1;
        logic [DW-1:0] got_d;
        logic [IW-1:0] got_id;
        logic [NS-1:0] got_req;
        k_ack = -1; n0 = 0; n1 = 0;
        got_d = 'x; got_id = 'x; got_req = 'x;
        din_v[2] = 32'h0000_abcd;
        auto_en  = 4'b0100;
        dst_req  = 1'b1;
        do_reset();
        for (int k = 1; k <= 30 && k_ack < 0; k++) begin
            @(negedge clk);
            if (src_req[0] === 1'b1) n0++;
            if (src_req[1] === 1'b1) n1++;
            if (dst_ack === 1'b1) begin
                k_ack   = k;
                got_d   = dst_dout;
                got_id  = dst_id;
                got_req = src_req;
            end
        end
        n_tests++;
        if (n0 != WC) begin n_fail++; $display("FAIL t2_poll0_cycles: got %0d want %0d", n0, WC); end
        n_tests++;
        if (n1 != WC) begin n_fail++; $display("FAIL t2_poll1_cycles: got %0d want %0d", n1, WC); end
        n_tests++;
        if (k_ack != 2 * (WC + 1) + 4) begin
            n_fail++; $display("FAIL t2_ack_cycle: got %0d want %0d", k_ack, 2 * (WC + 1) + 4);
        end
        n_tests++;
        if (got_id !== 2'd2) begin n_fail++; $display("FAIL t2_id: got %0d want 2", got_id); end
        n_tests++;
        if (got_d !== 32'h0000_abcd) begin n_fail++; $display("FAIL t2_dout: got %h want abcd", got_d); end
        n_tests++;
        if (got_req !== 4'b1000) begin n_fail++; $display("FAIL t2_resume: got %b want 1000", got_req); end
    endtask

    task automatic test_all_ready();
        int n, prev_k;
        logic prev_ack;
        n = 0; prev_k = 0; prev_ack = 1'b0;
        for (int i = 0; i < NS; i++) din_v[i] = 32'(100 + i);
        auto_en = 4'b1111;
        dst_req = 1'b1;
        do_reset();
        for (int k = 1; k <= 40 && n < 8; k++) begin
            @(negedge clk);
            if (dst_ack === 1'b1) begin
                n_tests++;
                if (prev_ack) begin n_fail++; $display("FAIL t3_adjacent_ack: at cycle %0d", k); end
                n_tests++;
                if (dst_id !== IW'(n % NS)) begin
                    n_fail++; $display("FAIL t3_id: got %0d want %0d", dst_id, n % NS);
                end
                n_tests++;
                if (dst_dout !== 32'(100 + n % NS)) begin
                    n_fail++; $display("FAIL t3_dout: got %0d want %0d", dst_dout, 100 + n % NS);
                end
                n_tests++;
                if (k - prev_k != ((n == 0) ? 4 : 3)) begin
                    n_fail++; $display("FAIL t3_spacing: got %0d want %0d", k - prev_k, (n == 0) ? 4 : 3);
                end
                prev_k = k;
                n++;
            end
            prev_ack = (dst_ack === 1'b1);
        end
        n_tests++;
        if (n != 8) begin n_fail++; $display("FAIL t3_count: got %0d want 8", n); end
    endtask

    task automatic test_drain_catch();
        int seen;
        seen = 0;
        auto_en  = '0;
        dst_req  = 1'b1;
        din_v[0] = 32'd55;
        do_reset();
        for (int k = 1; k <= 20 && seen < WC; k++) begin
            @(negedge clk);
            if (src_req === 4'b0001) seen++;
        end
        @(posedge clk);
        #1 ack_inj = 4'b0001;
        @(negedge clk);
        n_tests++;
        if (src_req !== 4'b0000) begin n_fail++; $display("FAIL t4_req_dropped: got %b want 0000", src_req); end
        @(posedge clk);
        #1 ack_inj = '0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (dst_ack !== 1'b1) begin n_fail++; $display("FAIL t4_ack: got %b want 1", dst_ack); end
        n_tests++;
        if (dst_dout !== 32'd55) begin n_fail++; $display("FAIL t4_dout: got %0d want 55", dst_dout); end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL t4_err: got %b want 0", err); end
    endtask

    task automatic test_backpressure();
        int k, bad_req, bad_dout;
        bad_req = 0; bad_dout = 0;
        din_v[0] = 32'd77;
        auto_en  = 4'b0001;
        dst_req  = 1'b1;
        do_reset();
        k = 0;
        while (dst_ack !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        dst_req  = 1'b0;
        din_v[0] = 32'd88;
        k = 0;
        while (src_req !== 4'b0001 && k < 40) begin @(negedge clk); k++; end
        k = 0;
        while (src_req !== 4'b0000 && k < 10) begin @(negedge clk); k++; end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (src_req !== 4'b0000 || dst_ack !== 1'b0) bad_req++;
            if (dst_dout !== 32'd77) bad_dout++;
        end
        n_tests++;
        if (bad_req != 0) begin n_fail++; $display("FAIL t5_idle_while_held: got %0d bad cycles want 0", bad_req); end
        n_tests++;
        if (bad_dout != 0) begin n_fail++; $display("FAIL t5_dout_held: got %0d bad cycles want 0", bad_dout); end
        dst_req = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dst_ack !== 1'b1 || dst_dout !== 32'd88) begin
            n_fail++; $display("FAIL t5_release: got ack=%b dout=%0d want ack=1 dout=88", dst_ack, dst_dout);
        end
    endtask

    task automatic test_stray_and_reset();
        int k;
        auto_en = '0;
        dst_req = 1'b0;
        do_reset();
        k = 0;
        while (src_req !== 4'b0010 && k < 30) begin @(negedge clk); k++; end
        ack_inj = 4'b1000;
        @(negedge clk);
        ack_inj = '0;
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL t6_err_set: got %b want 1", err); end
        auto_en = 4'b0010;
        k = 0;
        while (src_req !== 4'b0000 && k < 10) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        auto_en = '0;
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL t6_err_sticky: got %b want 1", err); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (src_req !== '0 || dst_ack !== 1'b0 || dst_dout !== '0 || dst_id !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_mid_reset: got req=%b ack=%b dout=%h id=%0d err=%b want all 0",
                     src_req, dst_ack, dst_dout, dst_id, err);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (src_req !== 4'b0001) begin n_fail++; $display("FAIL t6_first_poll: got %b want 0001", src_req); end
        @(negedge clk);
        n_tests++;
        if (dst_ack !== 1'b0) begin n_fail++; $display("FAIL t6_no_stale_word: got ack=%b want 0", dst_ack); end
    endtask

    task automatic test_random();
        logic prev_ack;
        int delivered;
        exp_t e;
        prev_ack  = 1'b0;
        delivered = 0;
        exp_q.delete();
        auto_en = 4'b1111;
        dst_req = 1'b0;
        do_reset();
        rand_mode = 1'b1;
        for (int c = 0; c < 1600; c++) begin
            if (c == 1500) begin
                rand_mode = 1'b0;
                auto_en   = '0;
            end
            @(posedge clk);
            #1 dst_req = (c >= 1500) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if ($countones(src_req) > 1) begin
                n_tests++; n_fail++; $display("FAIL rnd_onehot: got %b", src_req);
            end
            if (dst_ack === 1'b1) begin
                delivered++;
                n_tests++;
                if (prev_ack) begin n_fail++; $display("FAIL rnd_adjacent_ack: at cycle %0d", c); end
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_unexpected_word: got id=%0d dout=%h want none", dst_id, dst_dout);
                end else begin
                    e = exp_q.pop_front();
                    if (dst_id !== IW'(e.id) || dst_dout !== e.d) begin
                        n_fail++;
                        $display("FAIL rnd_word: got id=%0d dout=%h want id=%0d dout=%h", dst_id, dst_dout, e.id, e.d);
                    end
                    n_tests++;
                    if (src_req !== NS'(1 << ((e.id + 1) % NS))) begin
                        n_fail++;
                        $display("FAIL rnd_rr_resume: got %b want %b", src_req, NS'(1 << ((e.id + 1) % NS)));
                    end
                end
            end
            prev_ack = (dst_ack === 1'b1);
            for (int i = 0; i < NS; i++) begin
                if (src_ack[i] === 1'b1) exp_q.push_back('{i, din_v[i]});
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_undelivered: got %0d words left want 0", exp_q.size()); end
        n_tests++;
        if (delivered < 50) begin n_fail++; $display("FAIL rnd_throughput: got %0d words want >= 50", delivered); end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL rnd_err: got %b want 0", err); end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) din_v[i] = '0;
        test_reset();
        test_first_word();
        test_skip_idle();
        test_all_ready();
        test_drain_catch();
        test_backpressure();
        test_stray_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
